// File: rtl/biquad_seq_mc_pkg.sv
// Shared types and constants for the sequenced biquad: FSM and MAC opcodes,
// default sizes, and the saturation limits for a W-bit signed result.
package biquad_seq_mc_pkg;

  localparam int DEF_W    = 16;
  localparam int DEF_FRAC = 8;
  localparam int DEF_CH   = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_A1, S_A2, S_B0, S_B1, S_B2, S_UPD
  } state_t;

  typedef enum logic [2:0] {
    MAC_HOLD, MAC_LOAD_SUB, MAC_SUB, MAC_LOAD, MAC_ADD
  } mac_op_t;

  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// Shared signed multiply-accumulate with floor requantise and saturate.
// The requantised value and clip flag reflect the accumulator's next value.
module biquad_mac
  import biquad_seq_mc_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC,
  parameter int ACCW = 2 * W + 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  mac_op_t                op,
  input  logic                   clr,
  input  logic signed [W-1:0]    mul_a,
  input  logic signed [W-1:0]    mul_b,
  input  logic signed [ACCW-1:0] base,
  output logic signed [W-1:0]    res,
  output logic                   clip
);

  localparam logic signed [ACCW-1:0] HI = ACCW'(sat_hi(W));
  localparam logic signed [ACCW-1:0] LO = ACCW'(sat_lo(W));

  logic signed [2*W-1:0]  prod;
  logic signed [ACCW-1:0] prod_x;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_nxt;
  logic signed [ACCW-1:0] shifted;

  assign prod   = mul_a * mul_b;
  assign prod_x = {{(ACCW - 2 * W){prod[2*W-1]}}, prod};

  always_comb begin
    acc_nxt = acc;
    case (op)
      MAC_LOAD_SUB: acc_nxt = base - prod_x;
      MAC_SUB:      acc_nxt = acc - prod_x;
      MAC_LOAD:     acc_nxt = prod_x;
      MAC_ADD:      acc_nxt = acc + prod_x;
      default:      acc_nxt = acc;
    endcase
  end

  // Arithmetic shift gives floor division by 2^FRAC.
  always_comb begin
    shifted = acc_nxt >>> FRAC;
    res     = shifted[W-1:0];
    clip    = 1'b0;
    if (shifted > HI) begin
      res  = HI[W-1:0];
      clip = 1'b1;
    end else if (shifted < LO) begin
      res  = LO[W-1:0];
      clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else begin
      acc <= clr ? '0 : acc_nxt;
    end
  end

endmodule

// File: rtl/biquad_seq_mc.sv
// Multi-channel DF-II biquad sharing one MAC over a 7-cycle sequence; accepts
// only in IDLE (in_ready), result pulses y_valid 7 cycles after accept.
module biquad_seq_mc
  import biquad_seq_mc_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC,
  parameter int CH   = DEF_CH,
  parameter int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CHW-1:0]      in_ch,
  input  logic signed [W-1:0] UK,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] a2,
  output logic                y_valid,
  output logic [CHW-1:0]      y_ch,
  output logic signed [W-1:0] YK,
  output logic                sat
);

  localparam int             ACCW   = 2 * W + 3;
  localparam logic [CHW:0]   CH_LIM = (CHW + 1)'(CH);

  state_t state, state_nxt;

  logic signed [W-1:0] u_q, b0_q, b1_q, b2_q, a1_q, a2_q, fk;
  logic [CHW-1:0]      ch_q;
  logic signed [W-1:0] f1 [CH];
  logic signed [W-1:0] f2 [CH];
  logic                sat_f;
  logic                start;

  mac_op_t                mac_op;
  logic                   mac_clr;
  logic signed [W-1:0]    mul_a, mul_b, mac_res;
  logic signed [ACCW-1:0] base;
  logic                   mac_clip;

  assign base = {{(ACCW - W - FRAC){u_q[W-1]}}, u_q, {FRAC{1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start     = 1'b0;
    mac_op    = MAC_HOLD;
    mac_clr   = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        // Out-of-range channels are consumed here and never sequenced.
        if (in_valid && ({1'b0, in_ch} < CH_LIM)) begin
          start     = 1'b1;
          state_nxt = S_A1;
        end
      end
      S_A1: begin
        mac_op = MAC_LOAD_SUB; mul_a = a1_q; mul_b = f1[ch_q];
        state_nxt = S_A2;
      end
      S_A2: begin
        mac_op = MAC_SUB; mul_a = a2_q; mul_b = f2[ch_q]; mac_clr = 1'b1;
        state_nxt = S_B0;
      end
      S_B0: begin
        mac_op = MAC_LOAD; mul_a = b0_q; mul_b = fk;
        state_nxt = S_B1;
      end
      S_B1: begin
        mac_op = MAC_ADD; mul_a = b1_q; mul_b = f1[ch_q];
        state_nxt = S_B2;
      end
      S_B2: begin
        mac_op = MAC_ADD; mul_a = b2_q; mul_b = f2[ch_q];
        state_nxt = S_UPD;
      end
      S_UPD: begin
        mac_clr   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  biquad_mac #(.W(W), .FRAC(FRAC), .ACCW(ACCW)) u_mac (
    .clk   (clk),
    .reset (reset),
    .op    (mac_op),
    .clr   (mac_clr),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .base  (base),
    .res   (mac_res),
    .clip  (mac_clip)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      u_q <= '0; b0_q <= '0; b1_q <= '0; b2_q <= '0; a1_q <= '0; a2_q <= '0;
      ch_q    <= '0;
      fk      <= '0;
      sat_f   <= 1'b0;
      YK      <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      sat     <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        f1[i] <= '0;
        f2[i] <= '0;
      end
    end else begin
      y_valid <= 1'b0;
      sat     <= 1'b0;
      if (start) begin
        u_q  <= UK;  ch_q <= in_ch;
        b0_q <= b0;  b1_q <= b1;  b2_q <= b2;
        a1_q <= a1;  a2_q <= a2;
      end
      case (state)
        S_A2: begin
          fk    <= mac_res;
          sat_f <= mac_clip;
        end
        S_UPD: begin
          YK       <= mac_res;
          y_ch     <= ch_q;
          y_valid  <= 1'b1;
          sat      <= sat_f | mac_clip;
          f2[ch_q] <= f1[ch_q];
          f1[ch_q] <= fk;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_seq_mc.sv
// Randomised self-checking bench for biquad_seq_mc against a per-channel
// arithmetic model of the filter equations.
module tb_biquad_seq_mc;

  localparam int NCH = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_ch;
  logic signed [15:0] UK, b0, b1, b2, a1, a2;
  logic               y_valid;
  logic [1:0]         y_ch;
  logic signed [15:0] YK;
  logic               sat;

  int checks   = 0;
  int failures = 0;

  longint mf1 [NCH];
  longint mf2 [NCH];
  longint exp_y [$];
  int     exp_c [$];

  always #5 clk = ~clk;

  biquad_seq_mc #(.W(16), .FRAC(8), .CH(NCH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .UK(UK), .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .y_valid(y_valid), .y_ch(y_ch), .YK(YK), .sat(sat)
  );

  task automatic check(input string tag, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic longint rq(input longint acc, inout bit clipped);
    longint v;
    v = acc >>> 8;
    if (v > 32767) begin v = 32767; clipped = 1'b1; end
    else if (v < -32768) begin v = -32768; clipped = 1'b1; end
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      mf1[i] = 0;
      mf2[i] = 0;
    end
  endtask

  task automatic model(input int ch, input longint u, input longint cb0, input longint cb1,
                       input longint cb2, input longint ca1, input longint ca2,
                       output longint y, output bit s);
    bit c;
    longint f;
    c = 1'b0;
    f = rq(u * 256 - ca1 * mf1[ch] - ca2 * mf2[ch], c);
    y = rq(cb0 * f + cb1 * mf1[ch] + cb2 * mf2[ch], c);
    mf2[ch] = mf1[ch];
    mf1[ch] = f;
    s = c;
  endtask

  task automatic scramble();
    UK = 16'($urandom); b0 = 16'($urandom); b1 = 16'($urandom);
    b2 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
    in_ch = 2'($urandom);
  endtask

  // One accepted sample; inputs are scrambled after accept to prove latching.
  task automatic run(input int ch, input int u, input int cb0, input int cb1, input int cb2,
                     input int ca1, input int ca2, output int got_y, output int got_s);
    longint ey;
    bit es;
    bit has;
    int n;
    ey = 0; es = 1'b0;
    has = (ch < NCH);
    if (has) model(ch, u, cb0, cb1, cb2, ca1, ca2, ey, es);
    @(negedge clk);
    check("rdy_idle", in_ready, 1);
    in_valid = 1'b1; in_ch = 2'(ch); UK = 16'(u);
    b0 = 16'(cb0); b1 = 16'(cb1); b2 = 16'(cb2); a1 = 16'(ca1); a2 = 16'(ca2);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!y_valid && n < 12) begin
      scramble();
      @(negedge clk);
      n++;
    end
    got_y = int'(YK);
    got_s = int'(sat);
    if (has) begin
      check("latency", n, 7);
      check("yk", YK, ey);
      check("y_ch", y_ch, ch);
      check("sat", sat, es);
    end else begin
      check("no_out", y_valid, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int gy, gs, acc_n, busy_n, yv_n;
    longint ey;
    bit es;
    reset = 1'b1; in_valid = 1'b0; in_ch = '0;
    UK = '0; b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_yvalid", y_valid, 0);
    check("rst_yk", YK, 0);
    check("rst_ych", y_ch, 0);
    check("rst_sat", sat, 0);

    // Pass-through
    run(0, 100, 256, 0, 0, 0, 0, gy, gs);
    check("pass_100", gy, 100);
    check("pass_sat", gs, 0);
    run(0, -37, 256, 0, 0, 0, 0, gy, gs);
    check("pass_m37", gy, -37);

    // Recursive decay on ch0, then a fresh impulse on ch1
    do_reset();
    run(0, 256, 256, 0, 0, -128, 0, gy, gs); check("decay0", gy, 256);
    run(0, 0,   256, 0, 0, -128, 0, gy, gs); check("decay1", gy, 128);
    run(0, 0,   256, 0, 0, -128, 0, gy, gs); check("decay2", gy, 64);
    run(1, 256, 256, 0, 0, -128, 0, gy, gs); check("ch1_imp", gy, 256);

    // Saturation both directions
    run(2, 20000,  512, 0, 0, 0, 0, gy, gs);
    check("sat_pos", gy, 32767); check("sat_pos_flag", gs, 1);
    run(2, -20000, 512, 0, 0, 0, 0, gy, gs);
    check("sat_neg", gy, -32768); check("sat_neg_flag", gs, 1);

    // Out-of-range channel is consumed silently
    run(3, 1234, 256, 0, 0, 0, 0, gy, gs);

    // Continuous in_valid: one accept per 7 cycles, no duplication
    @(negedge clk);
    in_ch = 2'd1; b0 = 16'sd256; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
    in_valid = 1'b1;
    acc_n = 0; busy_n = 0; yv_n = 0;
    for (int k = 0; k < 28; k++) begin
      if (y_valid) begin
        yv_n++;
        check("hs_yk", YK, (exp_y.size() > 0) ? exp_y.pop_front() : 99999);
        check("hs_ych", y_ch, (exp_c.size() > 0) ? exp_c.pop_front() : 7);
      end
      if (in_ready) begin
        UK = 16'($urandom_range(0, 20000));
        model(1, longint'(UK), 256, 0, 0, 0, 0, ey, es);
        exp_y.push_back(ey);
        exp_c.push_back(1);
        acc_n++;
      end else begin
        busy_n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (y_valid) begin
        yv_n++;
        check("hs_yk", YK, (exp_y.size() > 0) ? exp_y.pop_front() : 99999);
        check("hs_ych", y_ch, (exp_c.size() > 0) ? exp_c.pop_front() : 7);
      end
      @(negedge clk);
    end
    check("hs_accepts", acc_n, 4);
    check("hs_busy", busy_n, 24);
    check("hs_outputs", yv_n, 4);

    // Reset while in B1 aborts the sample and clears channel state
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'd0; UK = 16'sd256;
    b0 = 16'sd256; b1 = '0; b2 = '0; a1 = -16'sd128; a2 = '0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    yv_n = 0;
    for (int k = 0; k < 10; k++) begin
      if (y_valid) yv_n++;
      @(negedge clk);
    end
    check("rst_mid_noout", yv_n, 0);
    run(0, 256, 256, 0, 0, -128, 0, gy, gs); check("post_rst0", gy, 256);
    run(0, 0,   256, 0, 0, -128, 0, gy, gs); check("post_rst1", gy, 128);
    run(0, 0,   256, 0, 0, -128, 0, gy, gs); check("post_rst2", gy, 64);

    // Randomised traffic across all channels plus out-of-range ones
    for (int i = 0; i < 40; i++) begin
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768,
          int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
          int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 599)) - 300,
          int'($urandom_range(0, 399)) - 200, gy, gs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
